branch_flush_ctrl: RTL and testbench

BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

---
 rtl/branch_flush_ctrl_pkg.sv | 17 +
 rtl/branch_flush_ctrl_sat_counter.sv | 22 ++
 rtl/branch_flush_ctrl.sv | 141 ++++++++++++++
 tb/tb_branch_flush_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/branch_flush_ctrl_pkg.sv
// Shared constants and types for the branch flush / stall controller.
package branch_flush_ctrl_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b11;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SQUASH = 2'b01,
    STALL  = 2'b10,
    HOLD   = 2'b11
  } state_t;

endpackage

// File: rtl/branch_flush_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter
  import branch_flush_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Pipeline PC/IF-ID/ID-EX control: branch redirect, load-use stall, memory hold.
module branch_flush_ctrl
  import branch_flush_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [1:0]       pcsrc,
  input  logic             load_use,
  input  logic             hold,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t     state, state_nxt;
  logic       pend_valid, pend_valid_nxt;
  logic [1:0] pend_sel, pend_sel_nxt;
  logic       taken;
  logic       run_eval;
  logic       redirect_en;
  logic [1:0] redirect_sel;
  logic       taken_inc, stall_inc;

  // pcsrc=10 is illegal and behaves as sequential
  assign taken = ex_valid && ((pcsrc == PCSRC_BR) || (pcsrc == PCSRC_JALR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pend_valid <= 1'b0;
      pend_sel   <= PCSRC_SEQ;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      pend_sel   <= pend_sel_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pend_valid_nxt = pend_valid;
    pend_sel_nxt   = pend_sel;
    pc_write       = 1'b1;
    pc_sel         = PCSRC_SEQ;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    run_eval       = 1'b0;
    redirect_en    = 1'b0;
    redirect_sel   = PCSRC_SEQ;
    taken_inc      = 1'b0;
    stall_inc      = 1'b0;

    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_nxt  = HOLD;
      // Only states that act on pcsrc can park a redirect while frozen
      if ((state == RUN || state == STALL) && taken) begin
        pend_valid_nxt = 1'b1;
        pend_sel_nxt   = pcsrc;
      end
    end else begin
      case (state)
        SQUASH: state_nxt = RUN;
        STALL: begin
          if (taken) begin
            redirect_en  = 1'b1;
            redirect_sel = pcsrc;
          end else begin
            state_nxt = RUN;
          end
        end
        HOLD: begin
          if (pend_valid) begin
            redirect_en    = 1'b1;
            redirect_sel   = pend_sel;
            pend_valid_nxt = 1'b0;
            pend_sel_nxt   = PCSRC_SEQ;
          end else begin
            run_eval = 1'b1;
          end
        end
        default: run_eval = 1'b1;
      endcase

      if (run_eval) begin
        if (taken) begin
          redirect_en  = 1'b1;
          redirect_sel = pcsrc;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
          state_nxt  = STALL;
        end else begin
          state_nxt = RUN;
        end
      end

      if (redirect_en) begin
        pc_sel     = redirect_sel;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        taken_inc  = 1'b1;
        state_nxt  = SQUASH;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .rst (rst),
    .inc (taken_inc),
    .clr (cnt_clr),
    .cnt (taken_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Scoreboard bench: driver queues hand-computed per-cycle expectations, monitor checks at negedge.
module tb_branch_flush_ctrl;

  localparam int W = 4;

  // {pc_write, pc_sel[1:0], ifid_write, ifid_flush, idex_flush}
  localparam logic [5:0] N   = 6'b1_00_1_00;
  localparam logic [5:0] R   = 6'b0_00_0_11;
  localparam logic [5:0] H   = 6'b0_00_0_00;
  localparam logic [5:0] S   = 6'b0_00_0_01;
  localparam logic [5:0] T01 = 6'b1_01_1_11;
  localparam logic [5:0] T11 = 6'b1_11_1_11;

  logic         clk = 1'b0;
  logic         rst, ex_valid, load_use, hold, cnt_clr;
  logic [1:0]   pcsrc;
  logic         pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0]   pc_sel;
  logic [W-1:0] taken_cnt, stall_cnt;

  typedef struct packed {
    logic [5:0]   ctl;
    logic [W-1:0] tc;
    logic [W-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;
  exp_t m_e, m_a;
  int   m_id;

  always #5 clk = ~clk;

  branch_flush_ctrl #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .pcsrc      (pcsrc),
    .load_use   (load_use),
    .hold       (hold),
    .cnt_clr    (cnt_clr),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .ifid_write (ifid_write),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .taken_cnt  (taken_cnt),
    .stall_cnt  (stall_cnt)
  );

  task automatic cyc(input logic r, input logic ev, input logic [1:0] ps,
                     input logic lu, input logic h, input logic c,
                     input logic [5:0] ctl, input int tc, input int sc);
    exp_t e;
    rst      = r;
    ex_valid = ev;
    pcsrc    = ps;
    load_use = lu;
    hold     = h;
    cnt_clr  = c;
    e.ctl = ctl;
    e.tc  = W'(tc);
    e.sc  = W'(sc);
    exp_q.push_back(e);
    id_q.push_back(ncyc);
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_e  = exp_q.pop_front();
      m_id = id_q.pop_front();
      m_a  = {pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, taken_cnt, stall_cnt};
      total++;
      if (m_a !== m_e) begin
        bad++;
        $display("FAIL cyc%0d: got pcw/sel/ifw/iff/idf=%b tc=%0d sc=%0d, want %b tc=%0d sc=%0d",
                 m_id, m_a.ctl, m_a.tc, m_a.sc, m_e.ctl, m_e.tc, m_e.sc);
      end
    end
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; pcsrc = 2'b00; load_use = 1'b0; hold = 1'b0; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    //  rst ev pcsrc  lu h  c  ctl  tc sc
    cyc(1, 0, 2'b00, 0, 0, 0, R,   0, 0);   // reset state
    cyc(0, 0, 2'b00, 0, 0, 0, N,   0, 0);
    // branch redirect, then squash ignores inputs
    cyc(0, 1, 2'b01, 0, 0, 0, T01, 0, 0);
    cyc(0, 1, 2'b11, 1, 0, 0, N,   1, 0);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   1, 0);
    // load_use held 2 cycles -> one stall
    cyc(0, 0, 2'b00, 1, 0, 0, S,   1, 0);
    cyc(0, 0, 2'b00, 1, 0, 0, N,   1, 1);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   1, 1);
    // JALR beats load_use
    cyc(0, 1, 2'b11, 1, 0, 0, T11, 1, 1);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   2, 1);
    // illegal pcsrc and invalid EX are not taken
    cyc(0, 1, 2'b10, 0, 0, 0, N,   2, 1);
    cyc(0, 0, 2'b01, 0, 0, 0, N,   2, 1);
    // taken while in STALL
    cyc(0, 0, 2'b00, 1, 0, 0, S,   2, 1);
    cyc(0, 1, 2'b01, 1, 0, 0, T01, 2, 2);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   3, 2);
    // redirect parked across 3 hold cycles, applied from pending state
    cyc(0, 1, 2'b01, 0, 1, 0, H,   3, 2);
    cyc(0, 1, 2'b01, 0, 1, 0, H,   3, 2);
    cyc(0, 1, 2'b01, 0, 1, 0, H,   3, 2);
    cyc(0, 0, 2'b00, 0, 0, 0, T01, 3, 2);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   4, 2);
    // hold without pending: release evaluates as RUN
    cyc(0, 0, 2'b00, 0, 1, 0, H,   4, 2);
    cyc(0, 0, 2'b00, 1, 0, 0, S,   4, 2);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   4, 3);
    cyc(0, 1, 2'b11, 0, 0, 0, T11, 4, 3);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   5, 3);
    // reset during hold with pending redirect
    cyc(0, 1, 2'b11, 0, 1, 0, H,   5, 3);
    cyc(1, 1, 2'b11, 0, 1, 1, R,   5, 3);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   0, 0);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   0, 0);
    // 17 redirects saturate a 4-bit counter at 15
    for (int i = 0; i < 17; i++) begin
      cyc(0, 1, 2'b01, 0, 0, 0, T01, (i > 15) ? 15 : i, 0);
      cyc(0, 0, 2'b00, 0, 0, 0, N,   (i + 1 > 15) ? 15 : i + 1, 0);
    end
    // clear beats a simultaneous redirect increment
    cyc(0, 1, 2'b01, 0, 0, 1, T01, 15, 0);
    cyc(0, 0, 2'b00, 0, 0, 0, N,   0, 0);

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
